median3x3_stream: RTL and testbench

Pipelined, parametrised 3x3 rank filter for the image path. It accepts one 9-pixel window per cycle under a valid/ready handshake and returns the median of the window; minimum or maximum can be selected per window when compiled in. It replaces the fixed 8-bit, handshake-free median stage between the window-forming line buffer and the output writer, and adds backpressure and sideband tagging.

---
 rtl/median_pkg.sv | 25 ++
 rtl/sort3_cell.sv | 28 ++
 rtl/median3x3_stream.sv | 199 +++++++++++++++++++
 tb/tb_median3x3_stream.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared types and constants for the 3x3 rank filter.
// Mode encoding, default pixel width and window index helpers.
package median_pkg;

    typedef enum logic [1:0] {
        MODE_MED = 2'd0,
        MODE_MIN = 2'd1,
        MODE_MAX = 2'd2
    } rank_mode_t;

    localparam int DEF_DATA_W = 8;

    localparam int NUM_ROWS = 3;
    localparam int ROW_LEN  = 3;
    localparam int NUM_PIX  = NUM_ROWS * ROW_LEN;

    localparam int COL_L = 0;
    localparam int COL_M = 1;
    localparam int COL_H = 2;

    function automatic int pix_idx(input int row, input int col);
        return row * ROW_LEN + col;
    endfunction

endpackage

// File: rtl/sort3_cell.sv
// Combinational 3-input compare-swap sorter (unsigned).
// Three compare-swaps produce lo <= mid <= hi.
module sort3_cell #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] mid,
    output logic [DATA_W-1:0] hi
);

    logic [DATA_W-1:0] x_lo;
    logic [DATA_W-1:0] x_hi;
    logic [DATA_W-1:0] y_lo;

    // order a/b, push the larger against c, then order the two smalls
    always_comb begin
        x_lo = (a < b) ? a : b;
        x_hi = (a < b) ? b : a;
        y_lo = (x_hi < c) ? x_hi : c;
        hi   = (x_hi < c) ? c : x_hi;
        lo   = (x_lo < y_lo) ? x_lo : y_lo;
        mid  = (x_lo < y_lo) ? y_lo : x_lo;
    end

endmodule

// File: rtl/median3x3_stream.sv
// Pipelined 3x3 rank filter with valid/ready and sideband tag.
// Define MEDIAN3X3_MINMAX_EN to build the per-window min/max modes.
module median3x3_stream
    import median_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [9*DATA_W-1:0]     in_pix,
    input  logic [1:0]              in_mode,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_pix,
    output logic [TAG_W-1:0]        out_tag
);

    typedef logic [DATA_W-1:0] pix_t;

    logic advance;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    pix_t win [NUM_PIX];

    for (genvar k = 0; k < NUM_PIX; k++) begin : g_unpack
        assign win[k] = in_pix[k*DATA_W +: DATA_W];
    end

    pix_t r_lo  [NUM_ROWS];
    pix_t r_mid [NUM_ROWS];
    pix_t r_hi  [NUM_ROWS];

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        sort3_cell #(.DATA_W(DATA_W)) u_row (
            .a   (win[pix_idx(r, COL_L)]),
            .b   (win[pix_idx(r, COL_M)]),
            .c   (win[pix_idx(r, COL_H)]),
            .lo  (r_lo[r]),
            .mid (r_mid[r]),
            .hi  (r_hi[r])
        );
    end

    logic             s1_valid;
    pix_t             s1_lo  [NUM_ROWS];
    pix_t             s1_mid [NUM_ROWS];
    pix_t             s1_hi  [NUM_ROWS];
    logic [TAG_W-1:0] s1_tag;

    // S1: capture row-sorted pixels with tag and valid
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_tag   <= '0;
            for (int i = 0; i < NUM_ROWS; i++) begin
                s1_lo[i]  <= '0;
                s1_mid[i] <= '0;
                s1_hi[i]  <= '0;
            end
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_tag   <= in_tag;
            for (int i = 0; i < NUM_ROWS; i++) begin
                s1_lo[i]  <= r_lo[i];
                s1_mid[i] <= r_mid[i];
                s1_hi[i]  <= r_hi[i];
            end
        end
    end

    pix_t lo_lo, lo_mid, lo_hi;
    pix_t mid_lo, mid_mid, mid_hi;
    pix_t hi_lo, hi_mid, hi_hi;

    sort3_cell #(.DATA_W(DATA_W)) u_col_lo (
        .a   (s1_lo[0]),
        .b   (s1_lo[1]),
        .c   (s1_lo[2]),
        .lo  (lo_lo),
        .mid (lo_mid),
        .hi  (lo_hi)
    );

    sort3_cell #(.DATA_W(DATA_W)) u_col_mid (
        .a   (s1_mid[0]),
        .b   (s1_mid[1]),
        .c   (s1_mid[2]),
        .lo  (mid_lo),
        .mid (mid_mid),
        .hi  (mid_hi)
    );

    sort3_cell #(.DATA_W(DATA_W)) u_col_hi (
        .a   (s1_hi[0]),
        .b   (s1_hi[1]),
        .c   (s1_hi[2]),
        .lo  (hi_lo),
        .mid (hi_mid),
        .hi  (hi_hi)
    );

    logic             s2_valid;
    pix_t             s2_maxlo;
    pix_t             s2_medmid;
    pix_t             s2_minhi;
    logic [TAG_W-1:0] s2_tag;

    // S2: keep the three median candidates with tag and valid
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_maxlo  <= '0;
            s2_medmid <= '0;
            s2_minhi  <= '0;
            s2_tag    <= '0;
        end else if (advance) begin
            s2_valid  <= s1_valid;
            s2_maxlo  <= lo_hi;
            s2_medmid <= mid_mid;
            s2_minhi  <= hi_lo;
            s2_tag    <= s1_tag;
        end
    end

    pix_t cs_lo, cs_hi, cs_hmin, med_res, res;

    // median of the three candidates via two compare-swaps
    always_comb begin
        cs_lo   = (s2_maxlo < s2_medmid) ? s2_maxlo : s2_medmid;
        cs_hi   = (s2_maxlo < s2_medmid) ? s2_medmid : s2_maxlo;
        cs_hmin = (cs_hi < s2_minhi) ? cs_hi : s2_minhi;
        med_res = (cs_lo < cs_hmin) ? cs_hmin : cs_lo;
    end

`ifdef MEDIAN3X3_MINMAX_EN
    logic [1:0] s1_mode;
    logic [1:0] s2_mode;
    pix_t       s2_gmin;
    pix_t       s2_gmax;
    logic       unused_bits;

    assign unused_bits = ^{lo_mid, mid_lo, mid_hi, hi_mid};

    // mode rides alongside the data through S1 and S2
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_mode <= MODE_MED;
            s2_mode <= MODE_MED;
            s2_gmin <= '0;
            s2_gmax <= '0;
        end else if (advance) begin
            s1_mode <= in_mode;
            s2_mode <= s1_mode;
            s2_gmin <= lo_lo;
            s2_gmax <= hi_hi;
        end
    end

    // pick the rank requested for this window
    always_comb begin
        res = med_res;
        case (s2_mode)
            MODE_MIN: res = s2_gmin;
            MODE_MAX: res = s2_gmax;
            default:  res = med_res;
        endcase
    end
`else
    logic unused_bits;

    assign unused_bits = ^{lo_lo, lo_mid, mid_lo, mid_hi,
                           hi_mid, hi_hi, in_mode};

    // median only in this build
    always_comb begin
        res = med_res;
    end
`endif

    // S3: registered result, held while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_tag   <= '0;
        end else if (advance) begin
            out_valid <= s2_valid;
            out_pix   <= res;
            out_tag   <= s2_tag;
        end
    end

endmodule

// File: tb/tb_median3x3_stream.sv
// Directed bench for median3x3_stream.
// Scoreboard holds hand-computed results of accepted windows.
module tb_median3x3_stream;

    localparam int DW = 8;
    localparam int TW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [9*DW-1:0]   in_pix = '0;
    logic [1:0]        in_mode = 2'd0;
    logic [TW-1:0]     in_tag = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DW-1:0]     out_pix;
    logic [TW-1:0]     out_tag;

    median3x3_stream #(
        .DATA_W (DW),
        .TAG_W  (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pix    (in_pix),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] pix;
        logic [TW-1:0] tag;
        int            acyc;
    } exp_t;

    exp_t          q[$];
    int            n_chk = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            n_out = 0;
    bit            lat_chk = 0;
    bit            last_acc = 0;
    int            stall_lo = -1;
    int            stall_hi = -1;
    logic [DW-1:0] cur_exp = '0;

    logic [7:0] tbl [9][9] = '{
        '{  9,   1,   8,   2,   7,   3,   6,   4,   5},
        '{ 10,  20,  30,  40,  50,  60,  70,  80,  90},
        '{  3,   3,   3,   1,   1,   1,   2,   2,   2},
        '{100,   0, 200,  50, 150,  25,  75, 125, 175},
        '{  7,   7,   7,   7,   7,   7,   7,   7,   8},
        '{255, 254, 253,   0,   1,   2, 128, 127, 129},
        '{255, 255, 255, 255, 255, 255, 255, 255, 255},
        '{  0,   0,   0,   0,   0,   0,   0,   0,   0},
        '{  0, 255,   0, 255,   0, 255,   0, 255,   0}
    };

    logic [7:0] med [9] = '{5, 50, 2, 100, 7, 128, 255, 0, 0};

    function automatic logic [9*DW-1:0] win(input int i);
        logic [9*DW-1:0] v;
        v = '0;
        for (int k = 0; k < 9; k++) v[k*DW +: DW] = tbl[i][k];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)",
                     tag, got, want, cyc);
        end
    endtask

    // one clock: observe outputs before the edge, then advance
    task automatic step();
        bit ao;
        out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
        #1;
        last_acc = !rst && in_valid && in_ready;
        ao = out_valid && out_ready;
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", out_valid, 0);
            end else begin
                chk("out_pix", out_pix, q[0].pix);
                chk("out_tag", out_tag, q[0].tag);
                chk("in_ready_busy", in_ready, out_ready);
                if (ao) begin
                    if (lat_chk) chk("latency", cyc - q[0].acyc, 3);
                    void'(q.pop_front());
                    n_out++;
                end
            end
        end else begin
            chk("in_ready_idle", in_ready, 1);
        end
        if (last_acc) q.push_back('{cur_exp, in_tag, cyc});
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [9*DW-1:0] px, input logic [1:0] m,
                        input logic [TW-1:0] t, input logic [DW-1:0] e);
        int k;
        k = 0;
        in_pix   = px;
        in_mode  = m;
        in_tag   = t;
        cur_exp  = e;
        in_valid = 1'b1;
        do begin
            step();
            k++;
        end while (!last_acc && k < 20);
        if (!last_acc) chk("accept_timeout", last_acc, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic drain();
        int k;
        k = 0;
        in_valid = 1'b0;
        while (q.size() != 0 && k < 20) begin
            step();
            k++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        idle(2);
    endtask

    initial begin
        int base;
        int outs0;

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pix", out_pix, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_in_ready", in_ready, 1);

        lat_chk = 1;
        send(win(0), 2'd0, 4'd1, med[0]);
        drain();
        chk("single_count", n_out, 1);

`ifdef MEDIAN3X3_MINMAX_EN
        send(win(0), 2'd1, 4'd2, 8'd1);
        send(win(0), 2'd2, 4'd3, 8'd9);
        send(win(0), 2'd3, 4'd4, 8'd5);
        send(win(3), 2'd1, 4'd5, 8'd0);
        send(win(3), 2'd2, 4'd6, 8'd200);
        drain();
`else
        send(win(0), 2'd1, 4'd2, med[0]);
        send(win(0), 2'd2, 4'd3, med[0]);
        send(win(3), 2'd1, 4'd5, med[3]);
        drain();
`endif

        lat_chk = 0;
        outs0 = n_out;
        base = cyc;
        stall_lo = base + 4;
        stall_hi = base + 7;
        for (int i = 0; i < 6; i++)
            send(win(i), 2'd0, TW'(i + 8), med[i]);
        drain();
        stall_lo = -1;
        stall_hi = -1;
        chk("bp_count", n_out - outs0, 6);

        lat_chk = 1;
        for (int i = 6; i < 9; i++)
            send(win(i), 2'd0, TW'(i), med[i]);
        drain();

        send(win(1), 2'd0, 4'd14, med[1]);
        send(win(3), 2'd0, 4'd15, med[3]);
        in_valid = 1'b0;
        rst = 1'b1;
        q.delete();
        step();
        rst = 1'b0;
        idle(5);
        outs0 = n_out;
        send(win(5), 2'd0, 4'd7, med[5]);
        drain();
        chk("post_rst_count", n_out - outs0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
